// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the arbitrated ALU datapath.
package alu_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request after last_grant, wrapping modulo R.
module rr_arbiter #(
    parameter int R = 4,
    localparam int IW = $clog2(R)
) (
    input  logic [R-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [R-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic          found;
    logic [IW-1:0] idx;

    // R is a power of two, so IW-bit addition wraps the search naturally.
    always_comb begin
        grant     = '0;
        grant_idx = last_grant;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= R; k++) begin
            idx = last_grant + IW'(k);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin shared N-bit add/sub/logic datapath with an IDLE/EXEC/RESP sequencer.
// Optional macro ALU_ARB_FLAGS_EN adds the {carry, overflow} rsp_flags output.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N = 4,
    parameter int R = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [R-1:0]         req_valid,
    output logic [R-1:0]         req_ready,
    input  logic [R*N-1:0]       req_a,
    input  logic [R*N-1:0]       req_b,
    input  logic [R*OP_W-1:0]    req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [$clog2(R)-1:0] rsp_id,
    output logic [N-1:0]         rsp_data
`ifdef ALU_ARB_FLAGS_EN
    ,
    output logic [1:0]           rsp_flags
`endif
);

    localparam int IW = $clog2(R);

    state_e        state;
    logic [IW-1:0] last_grant;
    logic [R-1:0]  grant;
    logic [IW-1:0] grant_idx;

    logic [N-1:0]  op_a;
    logic [N-1:0]  op_b;
    alu_op_e       op_code;
    logic [IW-1:0] op_id;

    function automatic logic [N-1:0] alu_result(input logic [N-1:0] a, input logic [N-1:0] b,
                                                 input alu_op_e op);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a + ~b + N'(1);
            ALU_AND: return a & b;
            default: return a | b;
        endcase
    endfunction

`ifdef ALU_ARB_FLAGS_EN
    // Carry of a + ~b + 1 is already "not borrow", so ADD and SUB share one adder.
    function automatic logic [1:0] alu_flags(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input alu_op_e op);
        logic [N:0]   sum;
        logic [N-1:0] b_eff;
        if (op == ALU_ADD || op == ALU_SUB) begin
            b_eff = (op == ALU_SUB) ? ~b : b;
            sum   = {1'b0, a} + {1'b0, b_eff} + ((op == ALU_SUB) ? (N+1)'(1) : (N+1)'(0));
            return {sum[N], (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1])};
        end
        return 2'b00;
    endfunction
`endif

    rr_arbiter #(.R(R)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // Gated by rst_n so nothing is offered while reset is held.
    assign req_ready = (rst_n && state == ST_IDLE) ? grant : '0;

    // Operand capture carries no reset: it is only consumed after a real transfer.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && |req_valid) begin
            op_a    <= req_a[grant_idx*N +: N];
            op_b    <= req_b[grant_idx*N +: N];
            op_code <= alu_op_e'(req_op[grant_idx*OP_W +: OP_W]);
            op_id   <= grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= IW'(R-1);
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= '0;
`ifdef ALU_ARB_FLAGS_EN
            rsp_flags  <= 2'b00;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        state      <= ST_EXEC;
                        last_grant <= grant_idx;
                    end
                end
                ST_EXEC: begin
                    state     <= ST_RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= alu_result(op_a, op_b, op_code);
                    rsp_id    <= op_id;
`ifdef ALU_ARB_FLAGS_EN
                    rsp_flags <= alu_flags(op_a, op_b, op_code);
`endif
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand-written corner sequences, random run vs model.
module tb_alu_arbiter;

    localparam int N = 4;
    localparam int R = 4;
    localparam int MASK = (1 << N) - 1;
    localparam int HALF = 1 << (N - 1);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [R-1:0]   req_valid;
    logic [R-1:0]   req_ready;
    logic [R*N-1:0] req_a;
    logic [R*N-1:0] req_b;
    logic [R*2-1:0] req_op;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [N-1:0]   rsp_data;
`ifdef ALU_ARB_FLAGS_EN
    logic [1:0]     rsp_flags;
`endif

    always #5 clk = ~clk;

    alu_arbiter #(.N(N), .R(R)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
`ifdef ALU_ARB_FLAGS_EN
        ,
        .rsp_flags (rsp_flags)
`endif
    );

    int total = 0;
    int bad = 0;

    typedef struct {
        int id; int a; int b; int op; int d; int c; int v;
    } vec_t;

    typedef struct {
        int id; int d; int c; int v;
    } exp_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference arithmetic from plain integer math.
    function automatic int ref_data(input int a, input int b, input int op);
        case (op)
            0: return (a + b) & MASK;
            1: return (a - b) & MASK;
            2: return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic int ref_carry(input int a, input int b, input int op);
        if (op == 0) return ((a + b) > MASK) ? 1 : 0;
        if (op == 1) return (a >= b) ? 1 : 0;
        return 0;
    endfunction

    function automatic int ref_ovf(input int a, input int b, input int op);
        int sa, sb, r;
        sa = (a >= HALF) ? a - (1 << N) : a;
        sb = (b >= HALF) ? b - (1 << N) : b;
        if (op > 1) return 0;
        r = (op == 0) ? sa + sb : sa - sb;
        return (r < -HALF || r > HALF - 1) ? 1 : 0;
    endfunction

    task automatic set_req(input int id, input bit v, input int a, input int b, input int op);
        req_valid[id]       = v;
        req_a[id*N +: N]    = N'(a);
        req_b[id*N +: N]    = N'(b);
        req_op[id*2 +: 2]   = 2'(op);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_single(input vec_t v, input string tag);
        int n = 0;
        set_req(v.id, 1'b1, v.a, v.b, v.op);
        rsp_ready = 1'b1;
        #1;
        while (!req_ready[v.id] && n < 10) begin
            tick();
            n++;
        end
        chk({tag, " grant"}, req_ready, 32'(1 << v.id));
        tick();
        set_req(v.id, 1'b0, v.a, v.b, v.op);
        #1;
        chk({tag, " exec_vld"}, rsp_valid, 0);
        chk({tag, " exec_rdy"}, req_ready, 0);
        tick();
        chk({tag, " rsp_vld"}, rsp_valid, 1);
        chk({tag, " data"}, rsp_data, v.d);
        chk({tag, " id"}, rsp_id, v.id);
`ifdef ALU_ARB_FLAGS_EN
        chk({tag, " carry"}, rsp_flags[1], v.c);
        chk({tag, " ovf"}, rsp_flags[0], v.v);
`endif
        tick();
        chk({tag, " done_vld"}, rsp_valid, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gord[$];
        int gcyc[$];
        int rcyc[$];
        int rnk;
        logic [N-1:0] hd;
        logic [1:0]   hid;
        int pv[R], pa[R], pb[R], po[R];
        bit acc[R];
        int mstate, mlast, w;
        logic [R-1:0] exp_ready;
        exp_t q[$];
        exp_t e;

        vt[0] = '{2, 7, 6, 0, 13, 0, 1};
        vt[1] = '{1, 3, 5, 1, 14, 0, 0};
        vt[2] = '{0, 10, 12, 2, 8, 0, 0};
        vt[3] = '{3, 10, 5, 3, 15, 0, 0};
        vt[4] = '{1, 15, 1, 0, 0, 1, 0};
        vt[5] = '{2, 8, 1, 1, 7, 1, 1};
        vt[6] = '{0, 5, 5, 1, 0, 1, 0};

        // Reset with every requester asking.
        req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b1;
        for (int i = 0; i < R; i++) set_req(i, 1'b1, 9, 3, i);
        repeat (3) tick();
        chk("rst req_ready", req_ready, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst rsp_data", rsp_data, 0);
        chk("rst rsp_id", rsp_id, 0);
        rst_n = 1'b1;
        #1;
        chk("rst first grant", req_ready, 1);

        // Fairness: all valid, distinct ops, no backpressure.
        for (int c = 0; c < 15; c++) begin
            if (req_ready != 0) begin
                gord.push_back($clog2(req_ready));
                gcyc.push_back(c);
            end
            if (rsp_valid) begin
                rnk = rcyc.size();
                rcyc.push_back(c);
                chk("fair rsp id", rsp_id, rnk % R);
                chk("fair rsp data", rsp_data, ref_data(9, 3, rnk % R));
            end
            tick();
        end
        req_valid = '0;
        chk("fair grant count", gord.size(), 5);
        chk("fair rsp count", rcyc.size(), 5);
        for (int k = 0; k < 5 && k < gord.size(); k++) begin
            chk("fair order", gord[k], k % R);
            chk("fair spacing", gcyc[k], 3 * k);
        end
        for (int k = 0; k < 5 && k < rcyc.size(); k++) chk("fair rsp time", rcyc[k], 3 * k + 2);

        // Backpressure with requesters 1 and 3 waiting.
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 6, 3, 0);
        #1;
        chk("bp grant0", req_ready, 1);
        tick();
        set_req(0, 1'b0, 6, 3, 0);
        set_req(1, 1'b1, 2, 1, 1);
        set_req(3, 1'b1, 4, 8, 3);
        #1;
        chk("bp exec rdy", req_ready, 0);
        tick();
        hd = rsp_data;
        hid = rsp_id;
        chk("bp data", hd, 9);
        chk("bp id", hid, 0);
        for (int k = 0; k < 5; k++) begin
            chk("bp stall vld", rsp_valid, 1);
            chk("bp stall data", rsp_data, 9);
            chk("bp stall id", rsp_id, 0);
            chk("bp stall rdy", req_ready, 0);
            tick();
        end
        chk("bp still vld", rsp_valid, 1);
        rsp_ready = 1'b1;
        tick();
        chk("bp next grant1", req_ready, 2);
        tick();
        set_req(1, 1'b0, 2, 1, 1);
        tick();
        chk("bp rsp1 id", rsp_id, 1);
        chk("bp rsp1 data", rsp_data, 1);
        tick();
        chk("bp next grant3", req_ready, 8);
        tick();
        set_req(3, 1'b0, 4, 8, 3);
        tick();
        chk("bp rsp3 id", rsp_id, 3);
        chk("bp rsp3 data", rsp_data, 12);
        tick();

        // Reset asserted while in EXEC.
        set_req(2, 1'b1, 5, 6, 0);
        #1;
        chk("mid grant2", req_ready, 4);
        tick();
        set_req(2, 1'b0, 5, 6, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid rsp_valid", rsp_valid, 0);
        chk("mid rsp_data", rsp_data, 0);
        chk("mid rsp_id", rsp_id, 0);
        chk("mid req_ready", req_ready, 0);
`ifdef ALU_ARB_FLAGS_EN
        chk("mid rsp_flags", rsp_flags, 0);
`endif
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid hold vld", rsp_valid, 0);
        end
        rst_n = 1'b1;
        tick();
        tick();
        chk("mid after vld", rsp_valid, 0);

        // Directed vector table.
        for (int i = 0; i < 7; i++) run_single(vt[i], $sformatf("vec%0d", i));

        // Randomized run against the model.
        rst_n = 1'b0;
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        mstate = 0;
        mlast = R - 1;
        for (int i = 0; i < R; i++) begin pv[i] = 0; acc[i] = 0; pa[i] = 0; pb[i] = 0; po[i] = 0; end
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int i = 0; i < R; i++) begin
                if (acc[i]) pv[i] = 0;
                else if (pv[i] != 0 && $urandom_range(15) == 0) pv[i] = 0;
                if (pv[i] == 0 && !acc[i] && $urandom_range(2) == 0) begin
                    pv[i] = 1;
                    pa[i] = int'($urandom_range(MASK));
                    pb[i] = int'($urandom_range(MASK));
                    po[i] = int'($urandom_range(3));
                end
                set_req(i, pv[i] != 0, pa[i], pb[i], po[i]);
                acc[i] = 0;
            end
            rsp_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            exp_ready = '0;
            w = -1;
            if (mstate == 0) begin
                for (int k = 1; k <= R; k++) begin
                    if (w < 0 && pv[(mlast + k) % R] != 0) w = (mlast + k) % R;
                end
                if (w >= 0) exp_ready[w] = 1'b1;
            end
            chk("rnd req_ready", req_ready, exp_ready);
            chk("rnd rsp_valid", rsp_valid, mstate == 2);
            if (rsp_valid) begin
                if (q.size() == 0) chk("rnd orphan rsp", 1, 0);
                else begin
                    e = q[0];
                    chk("rnd rsp id", rsp_id, e.id);
                    chk("rnd rsp data", rsp_data, e.d);
`ifdef ALU_ARB_FLAGS_EN
                    chk("rnd rsp flags", rsp_flags, e.c * 2 + e.v);
`endif
                end
            end
            case (mstate)
                0: if (w >= 0) begin
                    e.id = w;
                    e.d = ref_data(pa[w], pb[w], po[w]);
                    e.c = ref_carry(pa[w], pb[w], po[w]);
                    e.v = ref_ovf(pa[w], pb[w], po[w]);
                    q.push_back(e);
                    mlast = w;
                    acc[w] = 1;
                    mstate = 1;
                end
                1: mstate = 2;
                default: if (rsp_ready) begin
                    if (q.size() > 0) void'(q.pop_front());
                    mstate = 0;
                end
            endcase
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
